// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-wide data memory: one request at a time,
// byte/halfword load extraction with extension, and sub-word stores done as read-modify-write.
module dmem_lsu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_we,
  output logic [31:0] o_mem_a,
  output logic [31:0] o_mem_wd,
  input  logic [31:0] i_mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  function automatic logic f_is_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = off[0];
      3'b010:  e = (off != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | off[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old word with the store byte/halfword.
  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] data,
                                          input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000: r[{off, 3'b000} +: 8] = data[7:0];
      3'b001: begin
        if (off[1]) begin
          r[31:16] = data[15:0];
        end else begin
          r[15:0] = data[15:0];
        end
      end
      default: r = data;
    endcase
    return r;
  endfunction

  state_t      r_state;
  logic        r_ready;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_mem_we;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;

  state_t      w_next_state;
  logic        w_fire;
  logic        w_err;
  logic        w_ready_nxt;
  logic        w_resp_valid_nxt;
  logic        w_resp_err_nxt;
  logic [31:0] w_resp_rdata_nxt;
  logic        w_mem_we_nxt;
  logic [31:0] w_mem_a_nxt;
  logic [31:0] w_mem_wd_nxt;

  // Next state plus next value of every output register, so all outputs come straight from flops.
  always_comb begin
    w_next_state     = r_state;
    w_fire           = 1'b0;
    w_err            = f_is_err(i_req_we, i_req_funct3, i_req_addr[1:0]);
    w_ready_nxt      = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = 32'd0;
    w_mem_we_nxt     = 1'b0;
    w_mem_a_nxt      = 32'd0;
    w_mem_wd_nxt     = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid && r_ready) begin
          w_fire = 1'b1;
          if (w_err) begin
            w_next_state     = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else if (!i_req_we || (i_req_funct3 == 3'b010)) begin
            w_next_state = S_ACCESS;
            w_mem_a_nxt  = {i_req_addr[31:2], 2'b00};
            w_mem_we_nxt = i_req_we;
            w_mem_wd_nxt = i_req_we ? i_req_wdata : 32'd0;
          end else begin
            w_next_state = S_RMW_RD;
            w_mem_a_nxt  = {i_req_addr[31:2], 2'b00};
          end
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_ACCESS: begin
        w_next_state     = S_RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = r_we ? 32'd0 : f_extend(i_mem_rd, r_funct3, r_off);
      end
      S_RMW_RD: begin
        w_next_state = S_RMW_WR;
        w_mem_we_nxt = 1'b1;
        w_mem_a_nxt  = r_mem_a;
        w_mem_wd_nxt = f_merge(i_mem_rd, r_wdata, r_funct3, r_off);
      end
      S_RMW_WR: begin
        w_next_state     = S_RESP;
        w_resp_valid_nxt = 1'b1;
      end
      S_RESP: begin
        w_next_state = S_IDLE;
        w_ready_nxt  = 1'b1;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_we     <= 1'b0;
      r_mem_a      <= 32'd0;
      r_mem_wd     <= 32'd0;
    end else begin
      r_state      <= w_next_state;
      r_ready      <= w_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_a      <= w_mem_a_nxt;
      r_mem_wd     <= w_mem_wd_nxt;
      if (w_fire) begin
        r_we     <= i_req_we;
        r_funct3 <= i_req_funct3;
        r_off    <= i_req_addr[1:0];
        r_wdata  <= i_req_wdata;
      end
    end
  end

  assign o_req_ready  = r_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;
  assign o_mem_we     = r_mem_we;
  assign o_mem_a      = r_mem_a;
  assign o_mem_wd     = r_mem_wd;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that sits between the core datapath and the word-wide data memory (`dmem`) and initiates every access to it. It accepts one RISC-V load/store request at a time over a valid/ready handshake and drives the memory's `WE`/`A`/`WD` inputs from registered state. It performs byte and halfword extraction with sign or zero extension for loads. Sub-word stores become a read-modify-write of the containing aligned word.

## Interface
- No parameters; data and address width fixed at 32.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; a transfer occurs when `req_valid && req_ready` at a rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; B uses [7:0], H uses [15:0].
- `resp_valid`  out  1  one-cycle pulse; response fields valid.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal access; no memory write occurred.
- `mem_we`  out  1  to dmem `WE`.
- `mem_a`  out  32  to dmem `A`; always word-aligned, `{addr[31:2],2'b00}`.
- `mem_wd`  out  32  to dmem `WD`.
- `mem_rd`  in  32  from dmem `RD`; combinational read, sampled in the same cycle `mem_a` is driven.

## Operation
- Little-endian: the byte at offset k=`addr[1:0]` occupies word bits [8k+7:8k]. The halfword at offset 2h occupies [16h+15:16h].
- The unit latches `req_*` on acceptance.
- Error conditions are checked on the latched request:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - funct3 ∈ {011,110,111}.
  - store with funct3 100/101.
- FSM states: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On transfer: error → RESP with err; load, or SW → ACCESS; SB/SH → RMW_RD.
- ACCESS:
  - Drive `mem_a`.
  - SW: `mem_we`=1, `mem_wd`=wdata.
  - Load: capture the extended lane of `mem_rd` into the rdata register.
  - Next state: RESP.
- RMW_RD:
  - Drive `mem_a` with `mem_we`=0.
  - Capture `mem_rd` with the target lane replaced by the store byte/halfword into the merge register.
  - Next state: RMW_WR.
- RMW_WR: `mem_we`=1, `mem_wd`=merge register; next state RESP.
- RESP: `resp_valid`=1 for exactly one cycle; next state IDLE. The response path has no backpressure.
- `mem_we`, `mem_a` and `mem_wd` derive only from state and latched registers, with no combinational path from `req_*`. In IDLE and RESP: `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- Extension: B sign-extends bit 7 of the lane, BU zero-extends, H sign-extends bit 15, HU zero-extends.

## Timing
- Request accepted at edge 0 (in IDLE).
- Latency to `resp_valid`:
  - error: high in cycle 1.
  - loads and SW: cycle 2.
  - SB/SH: cycle 3.
- `mem_we` is high for exactly one cycle per successful store and never high for loads or errors.
- Throughput: next request is accepted in the cycle after RESP. `req_ready`=0 in ACCESS, RMW_RD, RMW_WR, RESP.
- Reset (`rst`=0) takes effect asynchronously:
  - State goes to IDLE.
  - `req_ready`, `resp_valid`, `resp_err`, `mem_we` all go to 0; `resp_rdata`, `mem_a`, `mem_wd` go to 0.
  - All internal registers go to 0.
  - `req_ready` is held 0 while `rst`=0 and rises the first cycle after release.
- Reset mid-operation: the in-flight request is dropped, no response is issued, and no write is issued after `rst` falls. An RMW aborted in RMW_RD or RMW_WR before its write edge leaves memory unchanged.
- A request held on `req_*` while `req_ready`=0 is not consumed; it must be held stable until transfer.

## Test plan
- Preload dmem[1000]=0x21212121, dmem[1004]=0x23232323. LW 1004 → `resp_rdata`=0x23232323, `resp_err`=0, `resp_valid` in cycle 2, `mem_we` never high.
- SB 1001 wdata 0x000000AB → one `mem_we` pulse in cycle 2 with `mem_a`=1000, `mem_wd`=0x2121AB21; response in cycle 3. Then LB 1001 → 0xFFFFFFAB and LBU 1001 → 0x000000AB.
- SH 1006 wdata 0x0000BEEF → dmem[1004]=0xBEEF2323. Then LH 1006 → 0xFFFFBEEF and LHU 1006 → 0x0000BEEF.
- Errors, each with `resp_err`=1, rdata 0, `mem_we` never high, response in cycle 1:
  - LH 1003.
  - SW 1002.
  - load with funct3 011.
  - store with funct3 100.
- Back-to-back: `req_valid` held high with SW 1000 (0xDEADBEEF), then LW 1000. The second request is accepted only the cycle after the first RESP, and returns 0xDEADBEEF.
- Drive `rst`=0 during RMW_RD of SB 1000 0x55:
  - `mem_we` stays 0 and dmem[1000] remains 0x21212121.
  - No `resp_valid`.
  - After release, `req_ready`=1 and a subsequent LW 1000 returns 0x21212121.
